// File: rtl/act_pkg.sv
// Shared constants, index-result type and the saturating LUT-index helper for the activation arbiter.
package act_pkg;

    localparam int X_SHIFT = 50;
    localparam int IDX_MAX = 99;
    localparam int F_W     = 8;
    localparam int CNT_W   = 16;
    localparam int X_W     = 32;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);

    typedef struct packed {
        logic             clamp;
        logic [IDX_W-1:0] idx;
    } idx_res_t;

    // One extra bit of headroom keeps x+offset exact even at the 32-bit extremes.
    function automatic idx_res_t sat_index(input logic [X_W-1:0] x);
        logic signed [X_W:0] s;
        idx_res_t            r;
        s       = $signed({x[X_W-1], x}) + $signed((X_W+1)'(X_SHIFT));
        r.clamp = 1'b0;
        r.idx   = s[IDX_W-1:0];
        if (s[X_W]) begin
            r.clamp = 1'b1;
            r.idx   = '0;
        end else if (s > $signed((X_W+1)'(IDX_MAX))) begin
            r.clamp = 1'b1;
            r.idx   = IDX_W'(IDX_MAX);
        end
        return r;
    endfunction

endpackage

// File: rtl/activation_function.sv
// Sigmoid LUT: entry i = floor(255 * sigmoid((i - 50) / 10)); purely combinational.
module activation_function
    import act_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [F_W-1:0]   f
);

    localparam logic [F_W-1:0] SIG_LUT [0:IDX_MAX] = '{
          1,   1,   2,   2,   2,   2,   3,   3,   3,   4,
          4,   5,   5,   6,   6,   7,   8,   9,   9,  10,
         12,  13,  14,  16,  17,  19,  21,  23,  25,  27,
         30,  33,  36,  39,  42,  46,  50,  54,  59,  63,
         68,  73,  79,  84,  90,  96, 102, 108, 114, 121,
        127, 133, 140, 146, 152, 158, 164, 170, 175, 181,
        186, 191, 195, 200, 204, 208, 212, 215, 218, 221,
        224, 227, 229, 231, 233, 235, 237, 238, 240, 241,
        242, 244, 245, 245, 246, 247, 248, 248, 249, 249,
        250, 250, 251, 251, 251, 252, 252, 252, 252, 253
    };

    always_comb begin
        f = SIG_LUT[IDX_MAX];
        if (idx <= IDX_W'(IDX_MAX)) f = SIG_LUT[idx];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from the rotating pointer; the pointer
// moves past the winner only on cycles where the grant is actually taken (advance).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    localparam int CW = ID_W + 1;

    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        logic          found;
        logic [CW-1:0] cand;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
            if (!found && req[cand[ID_W-1:0]]) begin
                found                 = 1'b1;
                grant[cand[ID_W-1:0]] = 1'b1;
                grant_id              = cand[ID_W-1:0];
            end
        end
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant_id + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/activation_arbiter.sv
// Shares one sigmoid LUT among NUM_REQ requesters: RR grant -> S1 (id, index) -> LUT -> S2 (id, f).
// Response is valid the cycle after the accept edge plus one; a stalled S2 backs up into S1 and then req_ready.
module activation_arbiter
    import act_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [F_W-1:0]         rsp_f,
    output logic [CNT_W-1:0]       clamp_cnt
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               accept, s1_ready, s2_ready;
    logic [X_W-1:0]     sel_x;
    idx_res_t           sel_res;
    logic [F_W-1:0]     lut_f;

    logic               s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
    logic               s2_valid_q, s2_valid_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;
    logic [F_W-1:0]     s2_f_q, s2_f_d;
    logic [CNT_W-1:0]   clamp_cnt_q, clamp_cnt_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    activation_function u_lut (
        .idx (s1_idx_q),
        .f   (lut_f)
    );

    assign s2_ready  = !s2_valid_q || rsp_ready;
    assign s1_ready  = !s1_valid_q || s2_ready;
    // Gated by rst so nothing looks accepted while the pipeline is being cleared.
    assign req_ready = rst ? '0 : (grant & {NUM_REQ{s1_ready}});
    assign accept    = |req_ready;

    always_comb begin
        sel_x = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_x = req_x[i*X_W +: X_W];
        end
        sel_res = sat_index(sel_x);
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        s1_idx_d    = s1_idx_q;
        s2_valid_d  = s2_valid_q;
        s2_id_d     = s2_id_q;
        s2_f_d      = s2_f_q;
        clamp_cnt_d = clamp_cnt_q;
        if (s1_ready) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_id_d  = grant_id;
                s1_idx_d = sel_res.idx;
            end
        end
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_id_d = s1_id_q;
                s2_f_d  = lut_f;
            end
        end
        if (accept && sel_res.clamp && (clamp_cnt_q != '1)) clamp_cnt_d = clamp_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_idx_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            s2_f_q      <= '0;
            clamp_cnt_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_idx_q    <= s1_idx_d;
            s2_valid_q  <= s2_valid_d;
            s2_id_q     <= s2_id_d;
            s2_f_q      <= s2_f_d;
            clamp_cnt_q <= clamp_cnt_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_f     = s2_f_q;
    assign clamp_cnt = clamp_cnt_q;

endmodule

// File: tb/tb_activation_arbiter.sv
// Directed bench for activation_arbiter: reset, latency, clamping, round-robin, stall and mid-flight reset.
module tb_activation_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_x;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [7:0]   rsp_f;
    logic [15:0]  clamp_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_f [4] = '{127, 186, 68, 235};

    activation_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_f     (rsp_f),
        .clamp_cnt (clamp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_x(input int i, input logic [31:0] v);
        req_x[i*32 +: 32] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_x     = '0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id",    32'(rsp_id),    0);
        chk("rst_rsp_f",     32'(rsp_f),     0);
        chk("rst_clamp",     32'(clamp_cnt), 0);
        req_valid = 4'h0;
        step();
        step();
        rst = 1'b0;

        // single request, x=0: two-stage latency
        set_x(0, 32'd0);
        req_valid = 4'b0001;
        #1;
        chk("a_req_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        chk("a_s1_only", 32'(rsp_valid), 0);
        step();
        chk("a_rsp_valid", 32'(rsp_valid), 1);
        chk("a_rsp_id",    32'(rsp_id),    0);
        chk("a_rsp_f",     32'(rsp_f),     127);
        chk("a_clamp",     32'(clamp_cnt), 0);
        step();
        chk("a_drained", 32'(rsp_valid), 0);

        // clamping low then high
        set_x(1, -32'sd200);
        req_valid = 4'b0010;
        #1;
        chk("b_req_ready1", 32'(req_ready), 32'b0010);
        step();
        set_x(2, 32'd1000);
        req_valid = 4'b0100;
        #1;
        chk("b_req_ready2", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        chk("b_rsp1_id", 32'(rsp_id), 1);
        chk("b_rsp1_f",  32'(rsp_f),  1);
        step();
        chk("b_rsp2_id", 32'(rsp_id), 2);
        chk("b_rsp2_f",  32'(rsp_f),  253);
        chk("b_clamp",   32'(clamp_cnt), 2);
        step();
        chk("b_drained", 32'(rsp_valid), 0);

        // 32-bit extremes; pointer sits at 3 so requester 3 wins first
        set_x(3, 32'h7FFF_FFFF);
        set_x(0, 32'h8000_0000);
        req_valid = 4'b1001;
        #1;
        chk("c_grant3", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0001;
        #1;
        chk("c_grant0", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        chk("c_max_id", 32'(rsp_id), 3);
        chk("c_max_f",  32'(rsp_f),  253);
        step();
        chk("c_min_id", 32'(rsp_id), 0);
        chk("c_min_f",  32'(rsp_f),  1);
        chk("c_clamp",  32'(clamp_cnt), 4);
        step();

        // fresh reset, then all four streaming
        rst = 1'b1;
        #1;
        chk("d_rst_clamp", 32'(clamp_cnt), 0);
        step();
        rst = 1'b0;
        set_x(0, 32'd0);
        set_x(1, 32'd10);
        set_x(2, -32'sd10);
        set_x(3, 32'd25);
        req_valid = 4'hF;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk("d_grant", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                chk("d_rsp_valid", 32'(rsp_valid), 1);
                chk("d_rsp_id",    32'(rsp_id),    32'((c - 2) % 4));
                chk("d_rsp_f",     32'(rsp_f),     32'(exp_f[(c - 2) % 4]));
            end
            step();
        end
        req_valid = 4'h0;
        chk("d_tail_id6", 32'(rsp_id), 2);
        step();
        chk("d_tail_id7", 32'(rsp_id), 3);
        chk("d_tail_f7",  32'(rsp_f),  235);
        step();
        chk("d_drained", 32'(rsp_valid), 0);

        // downstream stall for three cycles
        req_valid = 4'hF;
        #1;
        chk("e_grant0", 32'(req_ready), 32'b0001);
        step();
        chk("e_grant1", 32'(req_ready), 32'b0010);
        step();
        rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("e_stall_ready", 32'(req_ready), 0);
            chk("e_stall_valid", 32'(rsp_valid), 1);
            chk("e_stall_id",    32'(rsp_id),    0);
            chk("e_stall_f",     32'(rsp_f),     127);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("e_release_id",    32'(rsp_id),    0);
        chk("e_release_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'h0;
        chk("e_next_id", 32'(rsp_id), 1);
        chk("e_next_f",  32'(rsp_f),  186);
        step();
        chk("e_last_id", 32'(rsp_id), 2);
        chk("e_last_f",  32'(rsp_f),  68);
        step();
        chk("e_drained", 32'(rsp_valid), 0);

        // reset while S1 and S2 both hold work
        set_x(3, 32'd1000);
        req_valid = 4'hF;
        step();
        step();
        chk("f_pre_valid", 32'(rsp_valid), 1);
        chk("f_pre_id",    32'(rsp_id),    3);
        chk("f_pre_f",     32'(rsp_f),     253);
        chk("f_pre_clamp", 32'(clamp_cnt), 1);
        rst = 1'b1;
        #1;
        chk("f_rst_valid", 32'(rsp_valid), 0);
        chk("f_rst_id",    32'(rsp_id),    0);
        chk("f_rst_f",     32'(rsp_f),     0);
        chk("f_rst_ready", 32'(req_ready), 0);
        chk("f_rst_clamp", 32'(clamp_cnt), 0);
        step();
        rst       = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("f_grant_low", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        chk("f_no_stale", 32'(rsp_valid), 0);
        step();
        chk("f_rsp_valid", 32'(rsp_valid), 1);
        chk("f_rsp_id",    32'(rsp_id),    0);
        chk("f_rsp_f",     32'(rsp_f),     127);
        step();
        chk("f_drained", 32'(rsp_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/activation_arbiter.md
ACTIVATION_ARBITER -- requirements
Module: activation_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of neuron requesters sharing one sigmoid LUT (2..16).
REQ-002 Parameter ID_W, default $clog2(NUM_REQ), is the requester-id width.
REQ-003 Port clk, input, 1, is the single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, is the asynchronous active-high reset.
REQ-005 Port req_valid, input, NUM_REQ, is the per-requester request-valid bit.
REQ-006 Port req_x, input, NUM_REQ*32, is the per-requester signed pre-activation, scaled by 10; slice i is bits [32i+31:32i].
REQ-007 Port req_ready, output, NUM_REQ, is the per-requester accept bit; one-hot or zero.
REQ-008 Port rsp_valid, output, 1, is the response-valid bit.
REQ-009 Port rsp_ready, input, 1, is the downstream accept bit.
REQ-010 Port rsp_id, output, ID_W, is the index of the requester that the response belongs to.
REQ-011 Port rsp_f, output, 8, is the sigmoid result scaled by 255.
REQ-012 Port clamp_cnt, output, 16, is a saturating count of requests whose index was clamped.

Function
REQ-013 A request i SHALL be accepted on a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-014 Arbitration SHALL be round-robin: search starts at pointer ptr; the first valid requester found is granted.
REQ-015 After a grant to i, ptr SHALL become (i+1) mod NUM_REQ; ptr SHALL be unchanged in cycles with no grant.
REQ-016 The pipeline SHALL have two registered stages: S1 holds id and LUT index; S2 holds id and LUT result.
REQ-017 Stall signals: s2_ready = !rsp_valid | rsp_ready and s1_ready = !s1_valid | s2_ready.
REQ-018 req_ready[i] SHALL equal grant[i] & s1_ready; it is combinational from req_valid, ptr and pipeline state.
REQ-019 Index SHALL be computed as x+50 in 33-bit signed arithmetic, then saturated to 0..99; no wrap on extreme x.
REQ-020 If the unsaturated index is <0 or >99, clamp_cnt SHALL increment on acceptance; it saturates at 16'hFFFF.
REQ-021 S2 SHALL load the LUT value of the S1 index when s2_ready and s1_valid are both high; rsp_valid = S2 valid.
REQ-022 Latency: a request accepted at edge N SHALL present rsp_valid at edge N+2 if rsp_ready stays high.
REQ-023 With rsp_ready held high, throughput SHALL be one response per cycle.
REQ-024 While rsp_valid=1 and rsp_ready=0, rsp_id and rsp_f SHALL hold stable.
REQ-025 When S1 and S2 are both full and stalled, req_ready SHALL be all-zero and no state advances.
REQ-026 Responses SHALL leave in acceptance order; no request is dropped or duplicated.

Reset
REQ-027 While rst=1: rsp_valid=0, rsp_id=0, rsp_f=0, clamp_cnt=0, ptr=0, S1/S2 valid=0, and req_ready forced to 0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight requests with no response emitted for them; the first accept after reset uses ptr=0.

Structure
REQ-029 Package act_pkg SHALL hold X_SHIFT=50, IDX_MAX=99, F_W=8 and CNT_W=16; the RTL SHALL use no literals for these.
REQ-030 The LUT SHALL be one instance of the team's sigmoid LUT module (activation_function) between S1 and S2; its output is truncated to F_W bits.
REQ-031 The round-robin arbiter MAY be a sub-module rr_arbiter (NUM_REQ in; grant out; ptr internal).

Verification
REQ-032 Scenario: req0 sends x=0 with rsp_ready=1 -> rsp_valid at edge N+2, rsp_id=0, rsp_f=127, clamp_cnt=0.
REQ-033 Scenario: req1 sends x=-200, then req2 sends x=1000 -> rsp_f=1 (id1), then rsp_f=253 (id2); clamp_cnt=2.
REQ-034 Scenario: all four requesters valid continuously from reset with distinct x -> grant order 0,1,2,3,0,...; one response per cycle.
REQ-035 Scenario: rsp_ready low for 3 cycles during a stream -> rsp_id/rsp_f held; req_ready=0 after S1 and S2 fill; no loss and order kept on release.
REQ-036 Scenario: rst pulsed while S1 and S2 are valid -> outputs zero immediately (asynchronous); stale results never appear; next grant goes to the lowest valid index.
REQ-037 Scenario: x=2147483647 and x=-2147483648 -> rsp_f=253 and rsp_f=1 respectively, with no overflow.
